sha1_msg_padder: RTL

//  Upstream feeder for the SHA1 core. Accepts a byte-serial message, applies FIPS 180-4 padding
//  (0x80, zero fill, 64-bit big-endian bit length) and presents 512-bit blocks one at a time.

---
 rtl/sha1_msg_padder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sha1_msg_padder.sv
// sha1_msg_padder: byte-serial message to padded 512-bit SHA-1 blocks with core handshake
module sha1_msg_padder #(
    parameter int LEN_W = 32
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         msg_valid,
    output logic         msg_ready,
    input  logic [7:0]   msg_data,
    input  logic         msg_last,
    output logic [0:511] blk_data,
    output logic         blk_start,
    output logic         blk_first,
    output logic         blk_final,
    input  logic         core_done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_PAD,
        ST_SEND,
        ST_WAIT,
        ST_LBLK
    } state_t;

    state_t             state_q, state_d;
    logic [6:0]         ptr_q, ptr_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic [1:0]         pend_q, pend_d;
    logic [0:511]       blk_data_q, blk_data_d;
    logic               first_q, first_d;
    logic               final_q, final_d;
    logic               msg_ready_q, msg_ready_d;
    logic               blk_start_q, blk_start_d;
    logic [63:0]        len;
    logic [8:0]         bidx;

    // message length in bits, big-endian field of the final block
    assign len  = 64'(count_q) << 3;
    // bit offset of the byte slot the pointer addresses
    assign bidx = {ptr_q[5:0], 3'b000};

    assign msg_ready = msg_ready_q;
    assign blk_start = blk_start_q;
    assign blk_data  = blk_data_q;
    assign blk_first = first_q;
    assign blk_final = final_q;

    // state and datapath registers; everything visible is registered
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            count_q     <= '0;
            pend_q      <= '0;
            blk_data_q  <= '0;
            first_q     <= 1'b0;
            final_q     <= 1'b0;
            msg_ready_q <= 1'b0;
            blk_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            pend_q      <= pend_d;
            blk_data_q  <= blk_data_d;
            first_q     <= first_d;
            final_q     <= final_d;
            msg_ready_q <= msg_ready_d;
            blk_start_q <= blk_start_d;
        end
    end

    // next state, block assembly and padding; ready/start follow the next state so they stay registered
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        count_d    = count_q;
        pend_d     = pend_q;
        blk_data_d = blk_data_q;
        first_d    = first_q;
        final_d    = final_q;
        case (state_q)
            ST_IDLE: begin
                ptr_d      = '0;
                count_d    = '0;
                pend_d     = '0;
                blk_data_d = '0;
                first_d    = 1'b1;
                final_d    = 1'b0;
                state_d    = ST_FILL;
            end
            ST_FILL: begin
                if (msg_valid && msg_ready_q) begin
                    blk_data_d[bidx +: 8] = msg_data;
                    ptr_d   = ptr_q + 7'd1;
                    count_d = count_q + LEN_W'(1);
                    if (msg_last) begin
                        state_d = ST_PAD;
                    end else if (ptr_q == 7'd63) begin
                        final_d = 1'b0;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_PAD: begin
                // bytes past the pointer are already zero, so only the marker and length are written
                if (ptr_q < 7'd64) blk_data_d[bidx +: 8] = 8'h80;
                if (ptr_q <= 7'd55) begin
                    blk_data_d[448 +: 64] = len;
                    final_d = 1'b1;
                end else begin
                    final_d = 1'b0;
                    pend_d  = (ptr_q == 7'd64) ? 2'd2 : 2'd1;
                end
                state_d = ST_SEND;
            end
            ST_SEND: state_d = ST_WAIT;
            ST_WAIT: begin
                if (core_done) begin
                    if (final_q) begin
                        state_d = ST_IDLE;
                    end else if (pend_q != 2'd0) begin
                        state_d = ST_LBLK;
                    end else begin
                        first_d    = 1'b0;
                        ptr_d      = '0;
                        blk_data_d = '0;
                        state_d    = ST_FILL;
                    end
                end
            end
            ST_LBLK: begin
                // trailing block: optional 0x80 marker, zero fill, bit length
                blk_data_d = {(pend_q == 2'd2) ? 8'h80 : 8'h00, 440'd0, len};
                final_d    = 1'b1;
                first_d    = 1'b0;
                pend_d     = 2'd0;
                state_d    = ST_SEND;
            end
            default: state_d = ST_IDLE;
        endcase
        msg_ready_d = (state_d == ST_FILL);
        blk_start_d = (state_d == ST_SEND);
    end

endmodule
